// File: rtl/tdc_pkg.sv
// Shared constants, timestamp word layout and fine-code decode for the TDC capture path.
package tdc_pkg;

  localparam int unsigned TDC_NUM_TAPS = 32;
  localparam int unsigned TDC_FINE_W   = $clog2(TDC_NUM_TAPS);
  localparam int unsigned TDC_COARSE_W = 16;
  localparam int unsigned TDC_CNT_W    = $clog2(TDC_NUM_TAPS + 1);
  localparam int unsigned TDC_TS_W     = 1 + TDC_COARSE_W + TDC_FINE_W;

  typedef struct packed {
    logic                    sat;
    logic [TDC_COARSE_W-1:0] coarse;
    logic [TDC_FINE_W-1:0]   fine;
  } ts_word_t;

  // Counting ones instead of finding the edge tolerates bubbles; result is {sat, fine}.
  function automatic logic [TDC_FINE_W:0] popcount_sat(input logic [TDC_NUM_TAPS-1:0] taps);
    logic [TDC_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(TDC_NUM_TAPS); i++) begin
      cnt = cnt + TDC_CNT_W'(taps[i]);
    end
    if (cnt > TDC_CNT_W'((1 << TDC_FINE_W) - 1)) begin
      return {1'b1, {TDC_FINE_W{1'b1}}};
    end
    return {1'b0, TDC_FINE_W'(cnt)};
  endfunction

endpackage

// File: rtl/tdc_ts_fifo.sv
// Show-ahead synchronous FIFO with a registered head word and registered full/empty flags.
module tdc_ts_fifo #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_push_ok_c,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_head;
  logic              r_full;
  logic              r_empty;

  logic              w_pop;
  logic              w_push;
  logic [AW:0]       w_wr_ptr_nxt;
  logic [AW:0]       w_rd_ptr_nxt;
  logic [DATA_W-1:0] w_head_nxt;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  always_comb begin
    w_pop        = i_pop & ~r_empty;
    w_push       = i_push & (~r_full | w_pop);
    w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
    w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
    w_head_nxt   = r_head;
    if (r_empty | w_pop) begin
      if (w_rd_ptr_nxt == r_wr_ptr) begin
        if (w_push) begin
          w_head_nxt = i_data;
        end
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_head   <= w_head_nxt;
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full   <= ((w_wr_ptr_nxt ^ w_rd_ptr_nxt) == {1'b1, {AW{1'b0}}});
    end
  end

  assign o_data      = r_head;
  assign o_push_ok_c = w_push;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: rtl/tdc_event_capture.sv
// Brings TDC stop events into the system clock, timestamps them {sat, coarse, fine}, and buffers them.
// Optional TDC_DROP_CNT_EN adds a saturating count of timestamps lost to FIFO overflow.
module tdc_event_capture
  import tdc_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = TDC_NUM_TAPS,
  parameter int unsigned FINE_W     = $clog2(NUM_TAPS),
  parameter int unsigned COARSE_W   = TDC_COARSE_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_arm,
  input  logic                         i_hit_async,
  input  logic [NUM_TAPS-1:0]          i_taps_raw,
  output logic [1+COARSE_W+FINE_W-1:0] o_ts_data,
  output logic                         o_ts_valid,
  input  logic                         i_ts_ready,
  output logic                         o_fifo_full
`ifdef TDC_DROP_CNT_EN
  ,
  output logic [7:0]                   o_drop_cnt
`endif
);

  localparam int unsigned TS_W = 1 + COARSE_W + FINE_W;

  logic                r_sync1;
  logic                r_sync2;
  logic                r_hit_d;
  logic [COARSE_W-1:0] r_coarse;
  logic [NUM_TAPS-1:0] r_taps_q;
  logic [COARSE_W-1:0] r_coarse_q;
  logic                r_cap_v;

  logic                w_rise;
  logic [FINE_W:0]     w_enc;
  ts_word_t            w_push_word;
  logic                w_push_ok_c;
  logic                w_empty;

  assign w_rise = r_sync2 & ~r_hit_d;

  // taps_raw is held stable by the source while the strobe is high, so it is safe to sample here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hit_d    <= 1'b0;
      r_coarse   <= '0;
      r_taps_q   <= '0;
      r_coarse_q <= '0;
      r_cap_v    <= 1'b0;
    end else begin
      r_sync1  <= i_hit_async;
      r_sync2  <= r_sync1;
      r_hit_d  <= r_sync2;
      r_coarse <= r_coarse + COARSE_W'(1);
      r_cap_v  <= w_rise & i_arm;
      if (w_rise && i_arm) begin
        r_taps_q   <= i_taps_raw;
        r_coarse_q <= r_coarse;
      end
    end
  end

  // Encode is folded into the FIFO write edge.
  always_comb begin
    w_enc              = popcount_sat(r_taps_q);
    w_push_word.sat    = w_enc[FINE_W];
    w_push_word.coarse = r_coarse_q;
    w_push_word.fine   = w_enc[FINE_W-1:0];
  end

  tdc_ts_fifo #(
    .DATA_W (TS_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (r_cap_v),
    .i_data      (w_push_word),
    .i_pop       (i_ts_ready),
    .o_data      (o_ts_data),
`ifdef TDC_DROP_CNT_EN
    .o_push_ok_c (w_push_ok_c),
`else
    .o_push_ok_c (),
`endif
    .o_full      (o_fifo_full),
    .o_empty     (w_empty)
  );

  assign o_ts_valid = ~w_empty;

`ifdef TDC_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (r_cap_v && !w_push_ok_c && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign w_push_ok_c = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_event_capture.sv
// Directed bench for tdc_event_capture: latency, fine decode, FIFO fill/overflow, arm, wrap, reset.
module tb_tdc_event_capture;
  import tdc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        hit_async;
  logic        ts_ready;
  logic [31:0] taps_raw;
  ts_word_t    ts_data;
  logic        ts_valid;
  logic        fifo_full;
`ifdef TDC_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  logic [15:0] exp_coarse;

  always #5 clk = ~clk;

  // Expected coarse value: clk edges since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  tdc_event_capture dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_arm       (arm),
    .i_hit_async (hit_async),
    .i_taps_raw  (taps_raw),
    .o_ts_data   (ts_data),
    .o_ts_valid  (ts_valid),
    .i_ts_ready  (ts_ready),
    .o_fifo_full (fifo_full)
`ifdef TDC_DROP_CNT_EN
    ,
    .o_drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_hit(input logic [31:0] taps);
    taps_raw   = taps;
    hit_async  = 1'b1;
    exp_coarse = 16'(cyc + 2);
  endtask

  task automatic do_hit(input logic [31:0] taps);
    start_hit(taps);
    tick(2);
    hit_async = 1'b0;
    tick(4);
  endtask

  task automatic pop_one();
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic check_ts(input string tag, input int fine, input logic sat, input logic [15:0] coarse);
    check({tag, "_valid"},  32'(ts_valid), 32'd1);
    check({tag, "_fine"},   32'(ts_data.fine), 32'(fine));
    check({tag, "_sat"},    32'(ts_data.sat), 32'(sat));
    check({tag, "_coarse"}, 32'(ts_data.coarse), 32'(coarse));
  endtask

  task automatic check_drop(input string tag, input int exp);
`ifdef TDC_DROP_CNT_EN
    check(tag, 32'(drop_cnt), 32'(exp));
`endif
  endtask

  initial begin
    rst = 1'b1; arm = 1'b1; hit_async = 1'b0; ts_ready = 1'b0; taps_raw = '0;
    tick(1);
    do_reset();

    check("rst_valid", 32'(ts_valid), 32'd0);
    check("rst_data",  32'(ts_data), 32'd0);
    check("rst_full",  32'(fifo_full), 32'd0);
    check_drop("rst_drop", 0);

    // First event: sampled at edge 10, captured at 12, visible after 13
    while (cyc < 10) tick(1);
    start_hit(32'h0000FFFF);
    tick(3);
    check("lat_early", 32'(ts_valid), 32'd0);
    tick(1);
    check_ts("first", 16, 1'b0, 16'd12);
    hit_async = 1'b0;
    pop_one();
    check("first_pop", 32'(ts_valid), 32'd0);
    tick(2);

    // Bubble word, with ready high during the push into an empty FIFO
    start_hit(32'h00017FFF);
    tick(2);
    hit_async = 1'b0;
    tick(1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
    check_ts("bubble", 16, 1'b0, exp_coarse);
    pop_one();
    tick(2);

    do_hit(32'hFFFFFFFF); check_ts("ones", 31, 1'b1, exp_coarse); pop_one();
    do_hit(32'h7FFFFFFF); check_ts("pc31", 31, 1'b0, exp_coarse); pop_one();
    do_hit(32'h00000000); check_ts("zero", 0, 1'b0, exp_coarse);  pop_one();

    // Overflow: five events, no readout
    for (int k = 1; k <= 5; k++) begin
      do_hit(32'((64'd1 << k) - 64'd1));
      if (k == 3) check("fill3_full", 32'(fifo_full), 32'd0);
      if (k == 4) check("fill4_full", 32'(fifo_full), 32'd1);
    end
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_head", 32'(ts_data.fine), 32'd1);
    check_drop("ovf_drop", 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d", k), 32'(ts_data.fine), 32'(k));
      pop_one();
    end
    check("drain_empty", 32'(ts_valid), 32'd0);

    // Full FIFO, 5th push coincides with a pop
    do_reset();
    for (int k = 1; k <= 4; k++) do_hit(32'((64'd1 << k) - 64'd1));
    check("pp_full", 32'(fifo_full), 32'd1);
    start_hit(32'h0000001F);
    tick(2);
    hit_async = 1'b0;
    tick(1);
    ts_ready = 1'b1;
    tick(1);
    ts_ready = 1'b0;
    tick(2);
    check("pp_full_after", 32'(fifo_full), 32'd1);
    check_drop("pp_drop", 0);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp_drain%0d", k), 32'(ts_data.fine), 32'(k));
      pop_one();
    end
    check("pp_empty", 32'(ts_valid), 32'd0);

    // Disarmed hit is dropped silently
    arm = 1'b0;
    do_hit(32'h0000FFFF);
    tick(2);
    check("disarm_valid", 32'(ts_valid), 32'd0);
    check_drop("disarm_drop", 0);
    arm = 1'b1;

    // Ready on an empty FIFO has no effect
    ts_ready = 1'b1;
    tick(2);
    ts_ready = 1'b0;
    check("rdy_empty", 32'(ts_valid), 32'd0);
    do_hit(32'h0000000F);
    check_ts("after_rdy", 4, 1'b0, exp_coarse);
    pop_one();
    check("after_rdy_pop", 32'(ts_valid), 32'd0);
    tick(2);

    // Reset one cycle into a hit discards it; coarse restarts at 0
    start_hit(32'h0000FFFF);
    tick(1);
    rst = 1'b1;
    tick(2);
    hit_async = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(3);
    check("rstf_valid", 32'(ts_valid), 32'd0);
    do_hit(32'h000000FF);
    check_ts("rstf_next", 8, 1'b0, 16'd5);
    pop_one();

    // Coarse wrap
    do_reset();
    while (cyc < 65533) tick(1);
    do_hit(32'h00000001);
    check_ts("wrap_top", 1, 1'b0, 16'hFFFF);
    pop_one();
    while (cyc < 65544) tick(1);
    do_hit(32'h00000003);
    check_ts("wrap_low", 2, 1'b0, 16'd10);
    pop_one();
    check("wrap_empty", 32'(ts_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
